mem_io_arbiter: RTL and testbench

- Shares the single data-memory port and the LED/switch IO bus between two requesters: CPU data port and debug/UART-loader port.
- Sits between those requesters and the memory/IO mux. Decodes each address into the memory region or the IO region.
- Arbitrates round-robin. Sequences the synchronous memory read latency and returns a one-cycle ack with read data.

---
 rtl/mem_io_arbiter_pkg.sv | 27 ++
 rtl/mem_io_rr_arb.sv | 41 ++++
 rtl/mem_io_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_io_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_arbiter_pkg.sv
// Shared definitions for the memory/IO arbiter: FSM state encoding, grant
// encoding, default IO base address and the 16->32 sign-extension helper.
`timescale 1ns/1ps

package mem_io_arbiter_pkg;

    // Addresses at or above this value select the IO region.
    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

    // Transaction sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

    // Switch data is a signed 16-bit quantity on a 32-bit bus.
    function automatic logic [31:0] sext16(input logic [15:0] val);
        return {{16{val[15]}}, val};
    endfunction

endpackage

// File: rtl/mem_io_rr_arb.sv
// Two-input round-robin grant logic. The grant is combinational from the
// request lines; the winner is remembered only when the caller takes it.
`timescale 1ns/1ps

module mem_io_rr_arb
    import mem_io_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_cpu_req,
    input  logic   i_dbg_req,
    input  logic   i_take,
    output grant_t o_grant,
    output logic   o_valid
);

    grant_t r_last_grant;

    // Pick the single requester, or on a tie the port that did not win last.
    // NOTE: every output gets a default first so no latch can be inferred.
    always_comb begin
        o_valid = i_cpu_req | i_dbg_req;
        o_grant = GNT_CPU;
        if (i_cpu_req && i_dbg_req) begin
            o_grant = (r_last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
        end else if (i_dbg_req) begin
            o_grant = GNT_DBG;
        end
    end

    // Remember the winner; reset to DBG so CPU wins the first tie.
    // NOTE: state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_DBG;
        end else if (i_take && o_valid) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/mem_io_arbiter.sv
// Shares one synchronous data-memory port and the LED/switch IO bus between
// the CPU data port and the debug/UART-loader port. Round-robin arbitration,
// address decode (>= IO_BASE is IO), read-latency sequencing, one-cycle ack.
// Optional build macro: MISALIGN_CHK_EN adds cpu_err/dbg_err and short-cuts
// accesses with addr[1:0] != 0 straight to the response with an error.
`timescale 1ns/1ps

module mem_io_arbiter
    import mem_io_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int          MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        io_rd,
    output logic        io_wr,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [15:0] io_rdata,
`ifdef MISALIGN_CHK_EN
    output logic        cpu_err,
    output logic        dbg_err,
`endif
    output logic        busy
);

    logic [1:0]  r_state;
    grant_t      r_grant;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_is_io;
    logic [1:0]  r_wait_cnt;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dbg_rdata;

    grant_t      w_grant;
    logic        w_req_valid;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_misaligned;
    logic        w_cap_en;
    logic [31:0] w_cap_data;
    grant_t      w_cap_port;

    mem_io_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cpu_req (cpu_req),
        .i_dbg_req (dbg_req),
        .i_take    (r_state == ST_IDLE),
        .o_grant   (w_grant),
        .o_valid   (w_req_valid)
    );

    assign w_sel_we    = (w_grant == GNT_CPU) ? cpu_we    : dbg_we;
    assign w_sel_addr  = (w_grant == GNT_CPU) ? cpu_addr  : dbg_addr;
    assign w_sel_wdata = (w_grant == GNT_CPU) ? cpu_wdata : dbg_wdata;

`ifdef MISALIGN_CHK_EN
    assign w_misaligned = (w_sel_addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Sequencer: latch the granted request, issue, wait out read latency, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= GNT_CPU;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_io    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        r_grant <= w_grant;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_is_io <= (w_sel_addr >= IO_BASE);
                        r_state <= w_misaligned ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_is_io || r_we || MEM_LAT == 1) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= 2'(MEM_LAT - 2);
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Decide when and what read data is captured, and for which port.
    always_comb begin
        w_cap_en   = 1'b0;
        w_cap_data = mem_rdata;
        w_cap_port = r_grant;
        case (r_state)
            ST_IDLE: begin
                w_cap_port = w_grant;
                w_cap_data = '0;
                w_cap_en   = w_req_valid && w_misaligned;
            end
            ST_ISSUE: begin
                if (!r_we) begin
                    if (r_is_io) begin
                        w_cap_en   = 1'b1;
                        w_cap_data = sext16(io_rdata);
                    end else if (MEM_LAT == 1) begin
                        w_cap_en = 1'b1;
                    end
                end
            end
            ST_WAIT:  w_cap_en = (r_wait_cnt == 2'd0);
            default:  w_cap_en = 1'b0;
        endcase
    end

    // Per-port read data registers; the non-granted port keeps its value.
    // NOTE: these are plain registers (not a memory array), so resetting them is cheap and required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else if (w_cap_en) begin
            if (w_cap_port == GNT_CPU) begin
                r_cpu_rdata <= w_cap_data;
            end else begin
                r_dbg_rdata <= w_cap_data;
            end
        end
    end

`ifdef MISALIGN_CHK_EN
    logic r_err;

    // Error flag for the transaction in flight, set when it was misaligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && w_req_valid) begin
            r_err <= w_misaligned;
        end
    end

    assign cpu_err = cpu_ack & r_err;
    assign dbg_err = dbg_ack & r_err;
`endif

    assign mem_en    = (r_state == ST_ISSUE) && !r_is_io;
    assign mem_we    = mem_en && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign io_rd     = (r_state == ST_ISSUE) && r_is_io && !r_we;
    assign io_wr     = (r_state == ST_ISSUE) && r_is_io && r_we;
    assign io_addr   = r_addr;
    assign io_wdata  = r_wdata;
    assign cpu_ack   = (r_state == ST_RESP) && (r_grant == GNT_CPU);
    assign dbg_ack   = (r_state == ST_RESP) && (r_grant == GNT_DBG);
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Directed bench for mem_io_arbiter (MEM_LAT=2): a table of single
// transactions plus hand-written sequences for arbitration fairness,
// early request drop and reset in the middle of a read.
// Honours MISALIGN_CHK_EN when the build defines it.
`timescale 1ns/1ps

module tb_mem_io_arbiter;

    localparam int TB_MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_ack, dbg_ack;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we, io_rd, io_wr, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, io_addr, io_wdata;
    logic [15:0] io_rdata;
`ifdef MISALIGN_CHK_EN
    logic        cpu_err, dbg_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_cpu_rdata = '0;
    logic [31:0] m_dbg_rdata = '0;

    always #5 clk = ~clk;

    mem_io_arbiter #(.MEM_LAT(TB_MEM_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
`ifdef MISALIGN_CHK_EN
        .cpu_err   (cpu_err),
        .dbg_err   (dbg_err),
`endif
        .busy      (busy)
    );

    // Strobe code is {mem_en, mem_we, io_rd, io_wr} in the issue cycle.
    typedef struct {
        logic        dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rdata;
        logic [15:0] io_rdata;
        logic [3:0]  exp_strb;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Run one transaction from an idle arbiter and check strobes, latency, data.
    task automatic run_txn(input vec_t v);
        logic got;
        logic wrong_ack;
        logic ack;
        int   ack_k;
        got       = 1'b0;
        wrong_ack = 1'b0;
        ack_k     = 0;
        @(posedge clk); #1;
        if (v.dbg) begin
            dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        mem_rdata = 32'hDEAD_BEEF;
        io_rdata  = 16'h5A5A;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk); #1;
            mem_rdata = (k == TB_MEM_LAT) ? v.mem_rdata : 32'hDEAD_BEEF;
            io_rdata  = (k == 1) ? v.io_rdata : 16'h5A5A;
            if (k == 1) begin
                check("issue_strobes", {28'd0, mem_en, mem_we, io_rd, io_wr}, {28'd0, v.exp_strb});
                if (v.exp_strb[3]) check("mem_addr", mem_addr, v.addr);
                if (v.exp_strb[2]) check("mem_wdata", mem_wdata, v.wdata);
                if (v.exp_strb[1] || v.exp_strb[0]) check("io_addr", io_addr, v.addr);
                if (v.exp_strb[0]) check("io_wdata", io_wdata, v.wdata);
            end else begin
                check("strobes_idle", {28'd0, mem_en, mem_we, io_rd, io_wr}, 32'd0);
            end
            ack = v.dbg ? dbg_ack : cpu_ack;
            if (v.dbg ? cpu_ack : dbg_ack) wrong_ack = 1'b1;
            if (ack) begin
                got   = 1'b1;
                ack_k = k;
                if (!v.we || v.exp_err) begin
                    if (v.dbg) m_dbg_rdata = v.exp_rdata;
                    else       m_cpu_rdata = v.exp_rdata;
                end
                check("ack_rdata", v.dbg ? dbg_rdata : cpu_rdata, v.dbg ? m_dbg_rdata : m_cpu_rdata);
`ifdef MISALIGN_CHK_EN
                check("ack_err", {31'd0, v.dbg ? dbg_err : cpu_err}, {31'd0, v.exp_err});
`endif
            end
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL ack_timeout: got no ack expected ack at cycle %0d", v.exp_lat);
        end else begin
            check("ack_latency", 32'(ack_k), 32'(v.exp_lat));
        end
        check("other_ack_quiet", {31'd0, wrong_ack}, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("busy_after_ack", {31'd0, busy}, 32'd0);
        check("cpu_rdata_hold", cpu_rdata, m_cpu_rdata);
        check("dbg_rdata_hold", dbg_rdata, m_dbg_rdata);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 16'h0,    4'b1100, 2, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 16'h0,    4'b1000, 3, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FC70, 32'h0, 32'h0, 16'h8001,         4'b0010, 2, 32'hFFFF_8001, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FC00, 32'h0000_00A5, 32'h0, 16'h0,    4'b0001, 2, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FBFC, 32'h0, 32'hCAFE_F00D, 16'h0,    4'b1000, 3, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FC04, 32'h0, 32'h0, 16'h7FFF,         4'b0010, 2, 32'h0000_7FFF, 1'b0};
`ifdef MISALIGN_CHK_EN
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0000_0055, 32'h0, 16'h0,    4'b0000, 1, 32'h0, 1'b1};
`else
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0000_0055, 32'h0, 16'h0,    4'b1100, 2, 32'h0, 1'b0};
`endif

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        mem_rdata = '0; io_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {25'd0, cpu_ack, dbg_ack, mem_en, mem_we, io_rd, io_wr, busy}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_io_wdata", io_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        rst_n = 1'b1;

        // Both ports request continuously from reset: strict CPU/DBG alternation.
        begin
            int n_acks;
            int idle_run;
            n_acks   = 0;
            idle_run = 0;
            @(posedge clk); #1;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'h1111_1111;
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0000_0200; dbg_wdata = 32'h2222_2222;
            for (int k = 1; k <= 40 && n_acks < 4; k++) begin
                @(posedge clk); #1;
                if (!busy) idle_run++;
                if (mem_en) begin
                    check("rr_issue_addr", mem_addr, (n_acks % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
                end
                if (cpu_ack || dbg_ack) begin
                    check("rr_order", {30'd0, cpu_ack, dbg_ack}, (n_acks % 2 == 0) ? 32'd2 : 32'd1);
                    if (n_acks > 0) check("rr_busy_gap", 32'(idle_run), 32'd1);
                    idle_run = 0;
                    n_acks++;
                end
            end
            if (n_acks < 4) begin
                n_checks++; n_errors++;
                $display("FAIL rr_timeout: got %0d acks expected 4", n_acks);
            end
            @(posedge clk); #1;
            cpu_req = 1'b0;
            dbg_req = 1'b0;
        end

        foreach (vecs[i]) run_txn(vecs[i]);

        // Request dropped and inputs changed mid-transaction: latched write still completes.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0030; cpu_wdata = 32'h0000_0077;
        @(posedge clk); #1;
        check("drop_mem_en", {31'd0, mem_en}, 32'd1);
        cpu_req = 1'b0; cpu_addr = 32'h0000_0999; cpu_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("drop_ack", {31'd0, cpu_ack}, 32'd1);
        check("drop_latched_addr", mem_addr, 32'h0000_0030);
        check("drop_latched_wdata", mem_wdata, 32'h0000_0077);
        @(posedge clk); #1;
        check("drop_done", {30'd0, cpu_ack, busy}, 32'd0);

        // Reset asserted in the WAIT cycle of a memory read aborts it.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_in_wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("abort_ctrl", {25'd0, cpu_ack, dbg_ack, mem_en, mem_we, io_rd, io_wr, busy}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_cpu_rdata", cpu_rdata, 32'd0);
        check("abort_dbg_rdata", dbg_rdata, 32'd0);
        @(posedge clk); #1;
        check("abort_next_cycle", {25'd0, cpu_ack, dbg_ack, mem_en, mem_we, io_rd, io_wr, busy}, 32'd0);
        rst_n = 1'b1;
        m_cpu_rdata = '0;
        m_dbg_rdata = '0;
        run_txn(vecs[4]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
